div_unit: RTL

Iterative multi-cycle integer divider for the execute stage; it produces the quotient/remainder pair that the ALU writes into HI/LO on a divide operation. It replaces the single-cycle combinational divider path with a radix-2 restoring divider: one quotient bit per clock, with a start/busy/done handshake toward the execute-stage control. The HI/LO write logic consumes `quotient` (→ LO) and `remainder` (→ HI) in the cycle `done` is high.

---
 rtl/div_unit_pkg.sv | 10 +
 rtl/div_step.sv | 21 ++
 rtl/div_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared constants and FSM state encoding for the iterative divider
package div_unit_pkg;
   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;
endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one radix-2 restoring step: shift in a dividend bit, trial-subtract the divisor
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] trial;

   // One extra bit beyond WIDTH+1 carries the borrow that marks a negative trial.
   always_comb begin
      shifted = {rem_in, bit_in};
      trial   = {1'b0, shifted} - {2'b00, divisor};
      q_bit   = ~trial[WIDTH+1];
      rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
   end
endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle restoring divider with start/busy/done handshake
// Optional signed support: DIV_SIGNED_EN
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic             cancel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH + 1);

   div_state_e       state, next_state;
   logic [WIDTH-1:0] rem, dvd, dvs;
   logic [CW-1:0]    cnt;
   logic             zero_div, accept, b_zero;
   logic [WIDTH-1:0] a_mag, b_mag, q_res, r_res, rem_next;
   logic             q_bit;

   assign b_zero = (b == '0);

`ifdef DIV_SIGNED_EN
   logic a_neg, b_neg, neg_q, neg_r;

   always_comb begin
      a_neg = is_signed & a[WIDTH-1];
      b_neg = is_signed & b[WIDTH-1];
      a_mag = a_neg ? -a : a;
      b_mag = b_neg ? -b : b;
      q_res = neg_q ? -dvd : dvd;
      r_res = neg_r ? -rem : rem;
   end

   // Divide-by-zero keeps the all-ones quotient, while the remainder re-signs back to a.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (accept) begin
         neg_q <= (a_neg ^ b_neg) & ~b_zero;
         neg_r <= a_neg;
      end
   end
`else
   logic unused_is_signed;
   assign unused_is_signed = is_signed;

   always_comb begin
      a_mag = a;
      b_mag = b;
      q_res = dvd;
      r_res = rem;
   end
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem),
      .bit_in  (dvd[WIDTH-1]),
      .divisor (dvs),
      .rem_out (rem_next),
      .q_bit   (q_bit)
   );

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      case (state)
         DIV_IDLE, DIV_DONE: begin
            next_state = DIV_IDLE;
            if (start && !cancel) begin
               accept     = 1'b1;
               next_state = DIV_BUSY;
            end
         end
         DIV_BUSY: begin
            if (cancel)
               next_state = DIV_IDLE;
            else if (cnt == '0)
               next_state = DIV_DONE;
         end
         default: next_state = DIV_IDLE;
      endcase
   end

   assign busy = (state == DIV_BUSY);
   assign done = (state == DIV_DONE);

   // A zero divisor loads a zero count, so the single BUSY cycle only writes the results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= DIV_IDLE;
         rem         <= '0;
         dvd         <= '0;
         dvs         <= '0;
         cnt         <= '0;
         zero_div    <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            dvs      <= b_mag;
            zero_div <= b_zero;
            cnt      <= b_zero ? '0 : CW'(WIDTH);
            rem      <= b_zero ? a_mag : '0;
            dvd      <= b_zero ? '1 : a_mag;
         end else if (state == DIV_BUSY && !cancel) begin
            if (cnt != '0) begin
               rem <= rem_next;
               dvd <= {dvd[WIDTH-2:0], q_bit};
               cnt <= cnt - 1'b1;
            end else begin
               quotient    <= q_res;
               remainder   <= r_res;
               div_by_zero <= zero_div;
            end
         end
      end
   end
endmodule
